// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider: flag bit positions and FSM states.
package seq_div_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module seq_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH:0]   divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // rem_i < divisor always holds, so a non-negative difference also has diff[WIDTH] clear.
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        diff    = {1'b0, shifted} - {1'b0, divisor_i};
        q_bit_o = (diff[WIDTH+1:WIDTH] == 2'b00);
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Iterative signed/unsigned divider, one quotient bit per clock, with {N,Z,C,V} flags.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             S,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [3:0]       Flag,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Rem,
    output logic [3:0]       New_Flag
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [3:0]       flag_in_q, flag_in_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [3:0]       new_flag_q, new_flag_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] in1_mag, in2_mag;
    logic [WIDTH-1:0] quo_signed, rem_signed;

    seq_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (prem_q),
        .dvd_bit_i(dvd_q[WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_q)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dvd_d      = dvd_q;
        prem_d     = prem_q;
        dvs_d      = dvs_q;
        in1_d      = in1_q;
        flag_in_d  = flag_in_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        rem_d      = rem_q;
        new_flag_d = new_flag_q;

        in1_mag    = (S && In1[WIDTH-1]) ? -In1 : In1;
        in2_mag    = (S && In2[WIDTH-1]) ? -In2 : In2;
        quo_signed = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
        rem_signed = neg_a_q ? -prem_q : prem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d     = in1_mag;
                    dvs_d     = {1'b0, in2_mag};
                    prem_d    = '0;
                    in1_d     = In1;
                    flag_in_d = Flag;
                    neg_a_d   = S & In1[WIDTH-1];
                    neg_b_d   = S & In2[WIDTH-1];
                    dz_d      = (In2 == '0);
                    ovf_d     = S && (In1 == MIN_NEG) && (In2 == '1);
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CALC;
                end
            end
            // The dividend register shifts left; quotient bits fill in from the LSB.
            ST_CALC: begin
                prem_d  = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dz_q) begin
                    result_d   = '1;
                    rem_d      = in1_q;
                    new_flag_d = flag_in_q | (4'b0001 << FLAG_V);
                end else if (ovf_q) begin
                    result_d   = MIN_NEG;
                    rem_d      = '0;
                    new_flag_d = '0;
                    new_flag_d[FLAG_N] = 1'b1;
                    new_flag_d[FLAG_V] = 1'b1;
                end else begin
                    result_d   = quo_signed;
                    rem_d      = rem_signed;
                    new_flag_d[FLAG_N] = quo_signed[WIDTH-1];
                    new_flag_d[FLAG_Z] = (quo_signed == '0);
                    new_flag_d[FLAG_C] = (rem_signed != '0);
                    new_flag_d[FLAG_V] = 1'b0;
                end
                count_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            dvd_q      <= '0;
            prem_q     <= '0;
            dvs_q      <= '0;
            in1_q      <= '0;
            flag_in_q  <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            rem_q      <= '0;
            new_flag_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dvd_q      <= dvd_d;
            prem_q     <= prem_d;
            dvs_q      <= dvs_d;
            in1_q      <= in1_d;
            flag_in_q  <= flag_in_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            rem_q      <= rem_d;
            new_flag_q <= new_flag_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Result   = result_q;
    assign Rem      = rem_q;
    assign New_Flag = new_flag_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: arithmetic reference model checked every cycle, plus directed literal cases.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        S;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [3:0]  Flag;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [31:0] Rem;
    logic [3:0]  New_Flag;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_div #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .S       (S),
        .In1     (In1),
        .In2     (In2),
        .Flag    (Flag),
        .busy    (busy),
        .done    (done),
        .Result  (Result),
        .Rem     (Rem),
        .New_Flag(New_Flag)
    );

    // Expected {Result, Rem, New_Flag} straight from the arithmetic rules.
    function automatic logic [67:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  fl;
        longint      sa;
        longint      sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a, f[3:1], 1'b1};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0, 4'b1001};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        fl = {q[31], q == 32'd0, r != 32'd0, 1'b0};
        return {q, r, fl};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Cycle-level model: a divide accepted at an edge finishes 33 edges later.
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [67:0] m_pend = '0;
    logic [67:0] m_out  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_pend = ref_div(S, In1, In2, Flag);
                    m_cnt  = 33;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out  = m_pend;
                    m_done = 1'b1;
                end
            end
        end
        #1;
        n_vec++;
        if ({busy, done, Result, Rem, New_Flag} !== {(m_cnt != 0), m_done, m_out}) begin
            n_fail++;
            $display("FAIL cycle t=%0t got busy=%b done=%b res=%h rem=%h flag=%b, want busy=%b done=%b res=%h rem=%h flag=%b",
                     $time, busy, done, Result, Rem, New_Flag, (m_cnt != 0), m_done,
                     m_out[67:36], m_out[35:4], m_out[3:0]);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] f, input logic [31:0] er, input logic [31:0] erm,
                          input logic [3:0] ef);
        int lat;
        @(negedge clk);
        start = 1'b1;
        S     = s;
        In1   = a;
        In2   = b;
        Flag  = f;
        @(negedge clk);
        start = 1'b0;
        S     = ~s;
        In1   = $urandom;
        In2   = $urandom;
        Flag  = 4'($urandom);
        wait_done(lat);
        chk({name, " latency"}, 32'(lat), 32'd33);
        chk({name, " Result"}, Result, er);
        chk({name, " Rem"}, Rem, erm);
        chk({name, " New_Flag"}, {28'd0, New_Flag}, {28'd0, ef});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        S     = 1'b0;
        In1   = '0;
        In2   = '0;
        Flag  = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset Result", Result, 32'd0);
        chk("reset Rem", Rem, 32'd0);
        chk("reset New_Flag", {28'd0, New_Flag}, 32'd0);
        rst_n = 1'b1;

        run_op("t1 100/7", 1'b0, 32'd100, 32'd7, 4'b0000, 32'd14, 32'd2, 4'b0010);
        run_op("t2 -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 4'b0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1010);
        run_op("t3 max/9", 1'b0, 32'hFFFF_FFFF, 32'd9, 4'b0000, 32'h1C71_C71C, 32'd3, 4'b0010);
        run_op("t4 5/0", 1'b1, 32'd5, 32'd0, 4'b0100, 32'hFFFF_FFFF, 32'd5, 4'b0101);
        run_op("t5 ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 32'h8000_0000, 32'd0, 4'b1001);
        run_op("t5 0/3", 1'b1, 32'd0, 32'd3, 4'b0000, 32'd0, 32'd0, 4'b0100);
        run_op("u 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 4'b0000, 32'hFFFF_FFFD, 32'd1, 4'b1010);

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1;
        S     = 1'b0;
        In1   = 32'd100;
        In2   = 32'd7;
        Flag  = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        In1   = 32'd9;
        In2   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("s6 ignored latency", 32'(lat), 32'd28);
        chk("s6 ignored Result", Result, 32'd14);
        chk("s6 ignored Rem", Rem, 32'd2);

        // Reset mid-division clears everything at once.
        @(negedge clk);
        start = 1'b1;
        In1   = 32'd1000;
        In2   = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s6 rst busy", {31'd0, busy}, 32'd0);
        chk("s6 rst done", {31'd0, done}, 32'd0);
        chk("s6 rst Result", Result, 32'd0);
        chk("s6 rst Rem", Rem, 32'd0);
        chk("s6 rst New_Flag", {28'd0, New_Flag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("s6 9/3", 1'b0, 32'd9, 32'd3, 4'b1111, 32'd3, 32'd0, 4'b0000);

        // Random traffic, including start-while-busy, back-to-back and sporadic resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            start = ($urandom_range(0, 2) == 0);
            S     = 1'($urandom_range(0, 1));
            In1   = pick();
            In2   = pick();
            Flag  = 4'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
